// File: rtl/hazard_pkg.sv
// Shared types for the OTTER pipeline hazard controller.
// Holds the stall FSM encoding and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [0:0] {
    HZ_IDLE,
    HZ_LU_STALL
  } hz_state_t;

  localparam logic [31:0] REG_X0 = '0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: sync active-low clear, increment enable.
// Ports: clk, clrN, inc -> count[W-1:0] (sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clrN,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clrN) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage OTTER pipe: load-use stall FSM,
// branch flush, memory-busy freeze. Outputs: PC/IF-DE enables, bubble
// mux, pipe hold, flushes, status flags and saturating event counters.
import hazard_pkg::*;

module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic              de_ex_memRead,
  input  logic [REG_AW-1:0] de_ex_regRd,
  input  logic              ex_branchTaken,
  input  logic              mem_busy,
  output logic              pcWrite,
  output logic              de_write,
  output logic              controlMux,
  output logic              pipe_hold,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              loadUse,
  output logic              branchValid,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : gBadLat
    $error("hazard_ctrl_unit: LOAD_LAT must be 1..7");
  end

  hz_state_t     state;
  hz_state_t     stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;

  logic hit;
  logic rstAct;
  logic holdAct;
  logic flushAct;
  logic stallAct;

  always_comb begin
    hit = de_ex_memRead
        && (de_ex_regRd != REG_AW'(REG_X0))
        && ((de_rs1_used && (de_rs1 == de_ex_regRd))
         || (de_rs2_used && (de_rs2 == de_ex_regRd)));
  end

  // One-hot cycle class, priority already folded in
  always_comb begin
    rstAct   = !RST_N;
    holdAct  = RST_N && mem_busy;
    flushAct = RST_N && !mem_busy && ex_branchTaken;
    stallAct = RST_N && !mem_busy && !ex_branchTaken
            && ((state == HZ_LU_STALL) || hit);
  end

  always_comb begin
    pcWrite     = 1'b1;
    de_write    = 1'b1;
    controlMux  = 1'b0;
    pipe_hold   = 1'b0;
    flush_fd    = 1'b0;
    flush_de    = 1'b0;
    loadUse     = 1'b0;
    branchValid = 1'b0;
    stateNext   = state;
    cntNext     = cnt;
    unique case (1'b1)
      rstAct: begin
        stateNext = HZ_IDLE;
        cntNext   = '0;
      end
      holdAct: begin
        pipe_hold = 1'b1;
        pcWrite   = 1'b0;
        de_write  = 1'b0;
      end
      flushAct: begin
        flush_fd    = 1'b1;
        flush_de    = 1'b1;
        branchValid = 1'b1;
        stateNext   = HZ_IDLE;
        cntNext     = '0;
      end
      stallAct: begin
        pcWrite    = 1'b0;
        de_write   = 1'b0;
        controlMux = 1'b1;
        loadUse    = 1'b1;
        if (state == HZ_LU_STALL) begin
          cntNext = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            stateNext = HZ_IDLE;
          end
        end else if (LOAD_LAT > 1) begin
          // First bubble is this IDLE cycle; LOAD_LAT-1 remain
          stateNext = HZ_LU_STALL;
          cntNext   = CW'(LOAD_LAT - 1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) uLuCnt (
    .clk  (CLK),
    .clrN (RST_N),
    .inc  (loadUse),
    .count(lu_stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) uFlCnt (
    .clk  (CLK),
    .clrN (RST_N),
    .inc  (branchValid),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two instances (LOAD_LAT=3/CNT_W=2
// and LOAD_LAT=1/CNT_W=16) share stimulus and are checked against a model.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, busy;

  logic       aPc, aDw, aCm, aPh, aFf, aFd, aLu, aBv;
  logic [1:0] aLuc, aFlc;
  logic       bPc, bDw, bCm, bPh, bFf, bFd, bLu, bBv;
  logic [15:0] bLuc, bFlc;

  hazard_ctrl_unit #(
    .REG_AW(5), .LOAD_LAT(3), .CNT_W(2)
  ) dutA (
    .CLK(clk), .RST_N(rstN),
    .de_rs1(rs1), .de_rs2(rs2),
    .de_rs1_used(u1), .de_rs2_used(u2),
    .de_ex_memRead(mr), .de_ex_regRd(rd),
    .ex_branchTaken(br), .mem_busy(busy),
    .pcWrite(aPc), .de_write(aDw),
    .controlMux(aCm), .pipe_hold(aPh),
    .flush_fd(aFf), .flush_de(aFd),
    .loadUse(aLu), .branchValid(aBv),
    .lu_stall_cnt(aLuc), .flush_cnt(aFlc)
  );

  hazard_ctrl_unit #(
    .REG_AW(5), .LOAD_LAT(1), .CNT_W(16)
  ) dutB (
    .CLK(clk), .RST_N(rstN),
    .de_rs1(rs1), .de_rs2(rs2),
    .de_rs1_used(u1), .de_rs2_used(u2),
    .de_ex_memRead(mr), .de_ex_regRd(rd),
    .ex_branchTaken(br), .mem_busy(busy),
    .pcWrite(bPc), .de_write(bDw),
    .controlMux(bCm), .pipe_hold(bPh),
    .flush_fd(bFf), .flush_de(bFd),
    .loadUse(bLu), .branchValid(bBv),
    .lu_stall_cnt(bLuc), .flush_cnt(bFlc)
  );

  // {pcWrite,de_write,controlMux,pipe_hold,flush_fd,flush_de,loadUse,branchValid}
  localparam logic [7:0] NORM  = 8'b1100_0000;
  localparam logic [7:0] STALL = 8'b0010_0010;
  localparam logic [7:0] HOLD  = 8'b0001_0000;
  localparam logic [7:0] FLUSH = 8'b1100_1101;

  typedef struct {
    logic [7:0] bitsA;
    logic [7:0] bitsB;
    int         luA;
    int         luB;
    int         flA;
    int         flB;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // Model: bubbles still owed, and event counts per instance
  int lat[2]  = '{3, 1};
  int cmax[2] = '{3, 65535};
  int rem[2]  = '{0, 0};
  int lc[2]   = '{0, 0};
  int fc[2]   = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("A.flags", {24'd0, aPc, aDw, aCm, aPh, aFf, aFd, aLu, aBv}, {24'd0, e.bitsA});
      chk("B.flags", {24'd0, bPc, bDw, bCm, bPh, bFf, bFd, bLu, bBv}, {24'd0, e.bitsB});
      chk("A.luCnt", {30'd0, aLuc}, e.luA);
      chk("A.flCnt", {30'd0, aFlc}, e.flA);
      chk("B.luCnt", {16'd0, bLuc}, e.luB);
      chk("B.flCnt", {16'd0, bFlc}, e.flB);
    end
  end

  task automatic cyc(input logic r, input logic [4:0] a, input logic [4:0] b,
                     input logic ua, input logic ub, input logic m,
                     input logic [4:0] d, input logic bt, input logic bz);
    exp_t e;
    logic [7:0] bits[2];
    logic hit;
    @(posedge clk);
    #1;
    rstN = r; rs1 = a; rs2 = b; u1 = ua; u2 = ub;
    mr = m; rd = d; br = bt; busy = bz;
    hit = m && (d != 5'd0) && ((ua && a == d) || (ub && b == d));
    e.luA = lc[0]; e.luB = lc[1];
    e.flA = fc[0]; e.flB = fc[1];
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        bits[k] = NORM;
        rem[k] = 0; lc[k] = 0; fc[k] = 0;
      end else if (bz) begin
        bits[k] = HOLD;
      end else if (bt) begin
        bits[k] = FLUSH;
        rem[k] = 0;
        if (fc[k] < cmax[k]) fc[k]++;
      end else if (rem[k] > 0 || hit) begin
        bits[k] = STALL;
        rem[k] = (rem[k] > 0) ? rem[k] - 1 : lat[k] - 1;
        if (lc[k] < cmax[k]) lc[k]++;
      end else begin
        bits[k] = NORM;
      end
    end
    e.bitsA = bits[0];
    e.bitsB = bits[1];
    q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic luHit();
    cyc(1, 5, 0, 1, 0, 1, 5, 0, 0);
  endtask

  initial begin
    rstN = 0; rs1 = 0; rs2 = 0; rd = 0;
    u1 = 0; u2 = 0; mr = 0; br = 0; busy = 0;
    repeat (2) @(posedge clk);

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);

    luHit();
    nop(4);

    cyc(1, 0, 0, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 6, 1, 0, 1, 6, 0, 0);
    nop(1);

    cyc(1, 5, 0, 1, 0, 1, 5, 1, 0);
    nop(2);

    luHit();
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(4);

    luHit();
    nop(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);

    repeat (5) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(2);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end
    nop(2);

    repeat (3) @(negedge clk);
    chk("queueDrained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
